mult_div_unit: RTL

Iterative, parametrised multiply/divide unit owning the HI/LO register pair for MULT, MULTU, DIV, DIVU, MTHI and MTLO. It replaces the single-cycle combinational HI/LO path inside the ALU with a radix-2 sequential datapath, generalised to any `WIDTH`. It sits beside the ALU in the CPU datapath. The control unit stalls the PC on `busy` before MFHI/MFLO.

---
 rtl/mdu_pkg.sv | 19 +
 rtl/mult_div_unit_if.sv | 29 ++
 rtl/mdu_sign_fix.sv | 15 +
 rtl/mult_div_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mdu_pkg;

   localparam int unsigned DefaultWidth = 32;

   typedef enum logic [1:0] {
      OpMult  = 2'd0,
      OpMultu = 2'd1,
      OpDiv   = 2'd2,
      OpDivu  = 2'd3
   } mdu_op_e;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StCalc = 2'd1,
      StFix  = 2'd2
   } mdu_state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the CPU datapath and the multiply/divide unit.
interface mult_div_unit_if
   import mdu_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
);
   logic             clk_enable;
   logic             start;
   mdu_op_e          op;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output clk_enable, start, op, op_a, op_b, hi_we, lo_we, wdata,
      input  busy, done, hi, lo
   );

   modport slave (
      input  clk_enable, start, op, op_a, op_b, hi_we, lo_we, wdata,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate; used both for operand magnitudes and result signs.
module mdu_sign_fix #(
   parameter int unsigned Width = 32
) (
   input  logic [Width-1:0] val_i,
   input  logic             neg_i,
   output logic [Width-1:0] res_o
);

   // Negate when requested, otherwise pass through.
   always_comb begin
      res_o = neg_i ? (~val_i + Width'(1)) : val_i;
   end

endmodule

// File: rtl/mult_div_unit.sv
// Radix-2 sequential multiply/divide unit owning HI/LO.
// Optional MDU_EARLY_TERM_EN: multiplies leave CALC once the remaining multiplier bits are zero.
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input logic            clk,
   input logic            reset_n,
   mult_div_unit_if.slave bus
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);

   mdu_state_e         state_q, state_d;
   mdu_op_e            op_q, op_d;
   logic [WIDTH-1:0]   opa_q, opa_d;    // multiplicand, or dividend shifting out MSB first
   logic [WIDTH-1:0]   opb_q, opb_d;    // multiplier shifting out LSB first, or divisor
   logic [2*WIDTH-1:0] acc_q, acc_d;    // product, or {remainder, quotient}
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic               neg_res_q, neg_res_d;
   logic               neg_rem_q, neg_rem_d;
   logic               div0_q, div0_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   logic               in_signed, in_div, is_mul, calc_last;
   logic [WIDTH-1:0]   a_mag, b_mag, quo_res, rem_res;
   logic [WIDTH:0]     mul_sum, div_top, div_diff;
   logic [2*WIDTH-1:0] mul_acc, div_acc, prod, prod_res;

   assign in_signed = (bus.op == OpMult) || (bus.op == OpDiv);
   assign in_div    = (bus.op == OpDiv) || (bus.op == OpDivu);
   assign is_mul    = (op_q == OpMult) || (op_q == OpMultu);

   mdu_sign_fix #(.Width(WIDTH)) u_a_fix (
      .val_i (bus.op_a),
      .neg_i (in_signed & bus.op_a[WIDTH-1]),
      .res_o (a_mag)
   );

   mdu_sign_fix #(.Width(WIDTH)) u_b_fix (
      .val_i (bus.op_b),
      .neg_i (in_signed & bus.op_b[WIDTH-1]),
      .res_o (b_mag)
   );

   mdu_sign_fix #(.Width(2 * WIDTH)) u_prod_fix (
      .val_i (prod),
      .neg_i (neg_res_q),
      .res_o (prod_res)
   );

   mdu_sign_fix #(.Width(WIDTH)) u_quo_fix (
      .val_i (acc_q[WIDTH-1:0]),
      .neg_i (neg_res_q),
      .res_o (quo_res)
   );

   mdu_sign_fix #(.Width(WIDTH)) u_rem_fix (
      .val_i (acc_q[2*WIDTH-1:WIDTH]),
      .neg_i (neg_rem_q),
      .res_o (rem_res)
   );

   // One iteration of shift-add multiply and of restoring divide.
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (opb_q[0] ? opa_q : '0)};
      mul_acc  = {mul_sum, acc_q[WIDTH-1:1]};
      div_top  = {acc_q[2*WIDTH-1:WIDTH], opa_q[WIDTH-1]};
      div_diff = div_top - {1'b0, opb_q};
      // A borrow means the trial subtract failed; keep the shifted remainder.
      div_acc  = div_diff[WIDTH] ? {div_top[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                 : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
`ifdef MDU_EARLY_TERM_EN
      // Apply the shifts skipped by leaving CALC early.
      prod      = acc_q >> (CntW'(WIDTH) - cnt_q);
      calc_last = (cnt_q == CntW'(WIDTH - 1)) || (is_mul && ((opb_q >> 1) == '0));
`else
      prod      = acc_q;
      calc_last = (cnt_q == CntW'(WIDTH - 1));
`endif
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
      end else if (bus.clk_enable) begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (bus.start) state_d = StCalc;
         StCalc:  if (calc_last) state_d = StFix;
         StFix:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs.
   always_comb begin
      bus.busy = (state_q != StIdle);
      bus.done = done_q;
      bus.hi   = hi_q;
      bus.lo   = lo_q;
   end

   // Datapath next-state: accept, iterate, then sign-correct and write HI/LO.
   always_comb begin
      op_d      = op_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      div0_d    = div0_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.hi_we) hi_d = bus.wdata;
            if (bus.lo_we) lo_d = bus.wdata;
            if (bus.start) begin
               op_d      = bus.op;
               opa_d     = a_mag;
               opb_d     = b_mag;
               acc_d     = '0;
               cnt_d     = '0;
               neg_res_d = in_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
               neg_rem_d = in_signed & bus.op_a[WIDTH-1];
               div0_d    = in_div && (bus.op_b == '0);
            end
         end
         StCalc: begin
            cnt_d = cnt_q + CntW'(1);
            if (is_mul) begin
               acc_d = mul_acc;
               opb_d = opb_q >> 1;
            end else begin
               acc_d = div_acc;
               opa_d = opa_q << 1;
            end
         end
         StFix: begin
            done_d = 1'b1;
            if (is_mul) begin
               {hi_d, lo_d} = prod_res;
            end else begin
               // Divide by zero: the remainder path already yields op_a; force LO to all ones.
               hi_d = rem_res;
               lo_d = div0_q ? '1 : quo_res;
            end
         end
         default: ;
      endcase
   end

   // Datapath registers; everything holds while clk_enable is low.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_q      <= OpMult;
         opa_q     <= '0;
         opb_q     <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
         done_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else if (bus.clk_enable) begin
         op_q      <= op_d;
         opa_q     <= opa_d;
         opb_q     <= opb_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         div0_q    <= div0_d;
         done_q    <= done_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

endmodule
